stepper_cmd_queue: RTL and testbench

STEPPER_CMD_QUEUE -- requirements
Module: stepper_cmd_queue

---
 rtl/stepper_pkg.sv | 26 ++
 rtl/cmd_fifo.sv | 64 ++++++
 rtl/stepper_cmd_queue.sv | 111 +++++++++++
 tb/tb_stepper_cmd_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Command-word layout, mode encodings and FSM state encoding shared by the
// stepper command queue and its FIFO.
package stepper_pkg;
  localparam int CMD_W    = 32;
  localparam int MODE_MSB = 22;
  localparam int MODE_LSB = 21;
  localparam int POS_MSB  = 20;
  localparam int POS_LSB  = 0;

  localparam logic [1:0] MODE_MOVE = 2'b00;
  localparam logic [1:0] MODE_HOME = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_DWELL = 2'd2;

  function automatic logic is_home(input logic [CMD_W-1:0] cmd);
    return cmd[MODE_MSB:MODE_LSB] == MODE_HOME;
  endfunction

  // Bits above the mode field are reserved and must be zero in a valid command.
  function automatic logic is_reserved_clear(input logic [CMD_W-1:0] cmd);
    return cmd[CMD_W-1:MODE_MSB+1] == '0;
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: registered count/pointers, head shown combinationally.
// A push while full is refused (sticky overflow); flush empties it and beats a same-cycle push.
module cmd_fifo
  import stepper_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = CMD_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          do_pop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign push   = wr_en && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  assign head   = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en && full && !flush)
        overflow <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)
          rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(do_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wr_data;
  end
endmodule

// File: rtl/stepper_cmd_queue.sv
// Queues CPU stepper commands and issues them one per dwell window; write-to-strobe latency 1 clock.
// Writes while full are dropped (sticky overflow); STEPPER_CMD_VALIDATE_EN adds reserved-bit filtering and drop_count.
module stepper_cmd_queue
  import stepper_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int DWELL_CYCLES = 100000
) (
  input  logic                    CLK100MHZ,
  input  logic                    CPU_RESETN,
  input  logic                    wr_en,
  input  logic [CMD_W-1:0]        wr_data,
  input  logic                    flush,
  output logic [CMD_W-1:0]        data_out,
  output logic                    new_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
`ifdef STEPPER_CMD_VALIDATE_EN
  ,
  output logic [7:0]              drop_count
`endif
);
  localparam logic [21:0] DWELL_LOAD = 22'(DWELL_CYCLES);

  state_t             state;
  logic [21:0]        dwell_cnt;
  logic [CMD_W-1:0]   head;
  logic               pop;
  logic               wr_ok;

  assign pop = (state == ST_IDLE) && !empty && !flush;

`ifdef STEPPER_CMD_VALIDATE_EN
  assign wr_ok = wr_en && is_reserved_clear(wr_data);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)
      drop_count <= 8'd0;
    else if (wr_en && !is_reserved_clear(wr_data) && drop_count != 8'hFF)
      drop_count <= drop_count + 8'd1;
  end
`else
  assign wr_ok = wr_en;
`endif

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk      (CLK100MHZ),
    .rst_n    (CPU_RESETN),
    .wr_en    (wr_ok),
    .wr_data  (wr_data),
    .pop      (pop),
    .flush    (flush),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state     <= ST_IDLE;
      dwell_cnt <= '0;
      data_out  <= '0;
      new_data  <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      dwell_cnt <= '0;
      new_data  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          new_data <= 1'b0;
          if (pop) begin
            data_out <= head;
            new_data <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          new_data <= 1'b0;
          // Homing needs no settle time, so it goes straight back for the next command.
          if (is_home(data_out)) begin
            state <= ST_IDLE;
          end else begin
            dwell_cnt <= DWELL_LOAD;
            state     <= ST_DWELL;
          end
        end
        ST_DWELL: begin
          new_data <= 1'b0;
          if (dwell_cnt <= 22'd1) begin
            dwell_cnt <= '0;
            state     <= ST_IDLE;
          end else begin
            dwell_cnt <= dwell_cnt - 22'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          new_data <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stepper_cmd_queue.sv
// Directed bench: main DUT with DWELL_CYCLES=4, plus a long-dwell instance that
// holds its FSM in DWELL so the queue can be driven to full.
module tb_stepper_cmd_queue;
  logic        CLK100MHZ = 1'b0;
  logic        CPU_RESETN;
  logic        wr_en, flush;
  logic [31:0] wr_data, data_out;
  logic        new_data, full, empty, overflow;
  logic [3:0]  count;
  logic        h_wr_en, h_flush;
  logic [31:0] h_wr_data, h_data_out;
  logic        h_new_data, h_full, h_empty, h_overflow;
  logic [3:0]  h_count;
`ifdef STEPPER_CMD_VALIDATE_EN
  logic [7:0]  drop_count, h_drop_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] sq[$];
  int          sc[$];
  logic [31:0] hq[$];

  always #5 CLK100MHZ = ~CLK100MHZ;

  stepper_cmd_queue #(.DEPTH(8), .DWELL_CYCLES(4)) u_dut (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .wr_en(wr_en), .wr_data(wr_data),
    .flush(flush), .data_out(data_out), .new_data(new_data), .full(full), .empty(empty),
    .count(count), .overflow(overflow)
`ifdef STEPPER_CMD_VALIDATE_EN
    , .drop_count(drop_count)
`endif
  );

  stepper_cmd_queue #(.DEPTH(8), .DWELL_CYCLES(40)) u_dut_hold (
    .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN), .wr_en(h_wr_en), .wr_data(h_wr_data),
    .flush(h_flush), .data_out(h_data_out), .new_data(h_new_data), .full(h_full), .empty(h_empty),
    .count(h_count), .overflow(h_overflow)
`ifdef STEPPER_CMD_VALIDATE_EN
    , .drop_count(h_drop_count)
`endif
  );

  always @(posedge CLK100MHZ) cyc = cyc + 1;

  always @(negedge CLK100MHZ) begin
    if (new_data) begin
      sq.push_back(data_out);
      sc.push_back(cyc);
    end
    if (h_new_data) hq.push_back(h_data_out);
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK100MHZ);
      #1;
    end
  endtask

  task automatic test_reset;
    CPU_RESETN = 1'b0; wr_en = 0; flush = 0; wr_data = '0;
    h_wr_en = 0; h_flush = 0; h_wr_data = '0;
    step(2);
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h want %h", data_out, 32'h0); end
    checks++; if (new_data !== 1'b0) begin errors++; $display("FAIL reset_new_data: got %b want 0", new_data); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    CPU_RESETN = 1'b1;
    step(2);
  endtask

  task automatic test_single;
    int gap;
    sq.delete(); sc.delete();
    wr_en = 1; wr_data = 32'h0000_1234;
    step();
    wr_data = 32'h0000_5678;
    checks++; if (new_data !== 1'b0) begin errors++; $display("FAIL single_no_early_strobe: got %b want 0", new_data); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count_after_write: got %0d want 1", count); end
    step();
    wr_en = 0;
    checks++; if (new_data !== 1'b1) begin errors++; $display("FAIL single_latency_strobe: got %b want 1", new_data); end
    checks++; if (data_out !== 32'h0000_1234) begin errors++; $display("FAIL single_data: got %h want %h", data_out, 32'h0000_1234); end
    step();
    checks++; if (new_data !== 1'b0) begin errors++; $display("FAIL single_strobe_width: got %b want 0", new_data); end
    step(2);
    checks++; if (data_out !== 32'h0000_1234) begin errors++; $display("FAIL single_hold_in_dwell: got %h want %h", data_out, 32'h0000_1234); end
    for (int i = 0; i < 30 && sq.size() < 2; i++) step();
    checks++; if (sq.size() != 2) begin errors++; $display("FAIL single_second_issue: got %0d strobes want 2", sq.size()); end
    gap = (sq.size() >= 2) ? sc[1] - sc[0] : -1;
    checks++; if (!(gap >= 5)) begin errors++; $display("FAIL single_dwell_gap: got %0d cycles want >= 5", gap); end
    checks++; if (data_out !== 32'h0000_5678) begin errors++; $display("FAIL single_second_data: got %h want %h", data_out, 32'h0000_5678); end
    step(12);
  endtask

  task automatic test_home;
    int gap;
    sq.delete(); sc.delete();
    wr_en = 1; wr_data = 32'h0060_0000;
    step();
    wr_data = 32'h0000_0010;
    step();
    wr_en = 0;
    for (int i = 0; i < 20 && sq.size() < 2; i++) step();
    checks++; if (sq.size() != 2) begin errors++; $display("FAIL home_issue_count: got %0d want 2", sq.size()); end
    gap = (sq.size() >= 2) ? sc[1] - sc[0] : -1;
    checks++; if (gap != 2) begin errors++; $display("FAIL home_no_dwell_gap: got %0d cycles want 2", gap); end
    checks++; if (data_out !== 32'h0000_0010) begin errors++; $display("FAIL home_second_data: got %h want %h", data_out, 32'h0000_0010); end
    step(12);
  endtask

  task automatic test_overflow;
    hq.delete();
    h_wr_en = 1; h_wr_data = 32'h0000_0100;
    step();
    h_wr_en = 0;
    step(2);
    for (int i = 0; i < 9; i++) begin
      h_wr_en = 1; h_wr_data = 32'h0000_0200 + i;
      step();
    end
    h_wr_en = 0;
    checks++; if (h_count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d want 8", h_count); end
    checks++; if (h_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", h_full); end
    checks++; if (h_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", h_overflow); end
    for (int i = 0; i < 600 && hq.size() < 9; i++) step();
    step(100);
    checks++; if (hq.size() != 9) begin errors++; $display("FAIL ovf_issue_count: got %0d want 9", hq.size()); end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] got;
      got = (hq.size() > i + 1) ? hq[i+1] : 32'hFFFF_FFFF;
      checks++; if (got !== 32'h0000_0200 + i) begin errors++; $display("FAIL ovf_order_%0d: got %h want %h", i, got, 32'h0000_0200 + i); end
    end
    checks++; if (h_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", h_overflow); end
    checks++; if (h_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %b want 1", h_empty); end
  endtask

  task automatic prime_three(input logic [31:0] first);
    wr_en = 1; wr_data = first;
    step();
    for (int i = 1; i <= 3; i++) begin
      wr_data = 32'(i);
      step();
    end
  endtask

  task automatic test_flush;
    sq.delete(); sc.delete();
    prime_three(32'h0000_0777);
    flush = 1; wr_data = 32'h0000_DEAD;
    step();
    flush = 0; wr_en = 0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b want 1", empty); end
    checks++; if (new_data !== 1'b0) begin errors++; $display("FAIL flush_strobe: got %b want 0", new_data); end
    step(20);
    checks++; if (sq.size() != 1) begin errors++; $display("FAIL flush_no_more_issue: got %0d strobes want 1", sq.size()); end
    checks++; if (data_out !== 32'h0000_0777) begin errors++; $display("FAIL flush_data_kept: got %h want %h", data_out, 32'h0000_0777); end
  endtask

  task automatic test_reset_mid;
    sq.delete(); sc.delete();
    prime_three(32'h0000_0999);
    wr_en = 0;
    #2 CPU_RESETN = 1'b0;
    #1;
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rmid_data_out: got %h want %h", data_out, 32'h0); end
    checks++; if (new_data !== 1'b0) begin errors++; $display("FAIL rmid_new_data: got %b want 0", new_data); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rmid_full: got %b want 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow: got %b want 0", overflow); end
    step();
    CPU_RESETN = 1'b1;
    sq.delete(); sc.delete();
    step(20);
    checks++; if (sq.size() != 0) begin errors++; $display("FAIL rmid_no_strobe: got %0d strobes want 0", sq.size()); end
    wr_en = 1; wr_data = 32'h0000_0ABC;
    step();
    wr_en = 0;
    step();
    checks++; if (new_data !== 1'b1) begin errors++; $display("FAIL rmid_new_write_strobe: got %b want 1", new_data); end
    checks++; if (data_out !== 32'h0000_0ABC) begin errors++; $display("FAIL rmid_new_write_data: got %h want %h", data_out, 32'h0000_0ABC); end
    step(12);
  endtask

`ifdef STEPPER_CMD_VALIDATE_EN
  task automatic test_validate;
    sq.delete(); sc.delete();
    wr_en = 1; wr_data = 32'h0080_0001;
    step();
    wr_en = 0;
    checks++; if (drop_count !== 8'd1) begin errors++; $display("FAIL val_drop_one: got %0d want 1", drop_count); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL val_not_queued: got %0d want 0", count); end
    wr_en = 1;
    step(255);
    wr_en = 0;
    step(3);
    checks++; if (drop_count !== 8'd255) begin errors++; $display("FAIL val_saturate: got %0d want 255", drop_count); end
    checks++; if (sq.size() != 0) begin errors++; $display("FAIL val_no_issue: got %0d strobes want 0", sq.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_home();
    test_overflow();
    test_flush();
    test_reset_mid();
`ifdef STEPPER_CMD_VALIDATE_EN
    test_validate();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
